// File: rtl/ble_cmd_rx.sv
`default_nettype none
// ============================================================================
//  Module   : ble_cmd_rx
//  Purpose  : Receives the BLE module's UART byte stream, frames 7-byte drive
//             command packets (A5 FLAGS DIR_H DIR_L SPD_H SPD_L CSUM),
//             validates them and presents heading / speed / run enable to
//             the drive stage. A watchdog drops run_en when valid commands
//             stop arriving.
//  Ports    : clock         in   system clock
//             reset         in   asynchronous active-high reset
//             uart_rx       in   serial data, asynchronous, idles high
//             dir_degrees   out  [8:0] commanded heading 0..359
//             target_speed  out  [9:0] commanded speed 0..1023
//             run_en        out  motors enabled
//             cmd_valid     out  one-cycle pulse, packet accepted
//             cmd_err       out  one-cycle pulse, packet rejected / framing
//  Revision : 1.0  initial release
// ============================================================================
module ble_cmd_rx #(
    parameter int CLKS_PER_BIT  = 868,
    parameter int BYTE_GAP_CLKS = 200000,
    parameter int WATCHDOG_CLKS = 50000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [8:0] dir_degrees,
    output logic [9:0] target_speed,
    output logic       run_en,
    output logic       cmd_valid,
    output logic       cmd_err
);

    localparam int BIT_W = $clog2(CLKS_PER_BIT);
    localparam int GAP_W = $clog2(BYTE_GAP_CLKS + 1);
    localparam int WD_W  = $clog2(WATCHDOG_CLKS + 1);

    localparam logic [BIT_W-1:0] C_BIT_LAST  = BIT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] C_HALF_LAST = BIT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [GAP_W-1:0] C_GAP_LAST  = GAP_W'(BYTE_GAP_CLKS - 1);
    localparam logic [WD_W-1:0]  C_WD_LAST   = WD_W'(WATCHDOG_CLKS - 1);
    localparam logic [7:0]       C_HDR_BYTE  = 8'hA5;
    localparam logic [15:0]      C_DIR_MAX   = 16'd359;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [2:0] {
        P_HDR   = 3'd0,
        P_FLAGS = 3'd1,
        P_DIR_H = 3'd2,
        P_DIR_L = 3'd3,
        P_SPD_H = 3'd4,
        P_SPD_L = 3'd5,
        P_CSUM  = 3'd6
    } p_state_t;

    // ------------------------------------------------------------------
    // Synchronizer and UART receiver
    // ------------------------------------------------------------------
    logic             sync1_q;
    logic             sync2_q;
    logic             prev_q;
    rx_state_t        rx_state_q;
    logic [BIT_W-1:0] bit_cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             byte_stb_q;

    logic             bit_tick_w;
    logic             frame_err_w;

    assign bit_tick_w  = (bit_cnt_q == C_BIT_LAST);
    // Stop-bit sample low: reported in the same cycle so the parser can
    // register cmd_err one cycle after the failing sample.
    assign frame_err_w = (rx_state_q == RX_STOP) && bit_tick_w && !sync2_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            rx_state_q <= RX_IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            byte_stb_q <= 1'b0;
        end else begin
            sync1_q    <= uart_rx;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            byte_stb_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    // Edge-triggered start so a stuck-low line after a
                    // framing error does not retrigger endlessly.
                    if (prev_q && !sync2_q) begin
                        rx_state_q <= RX_START;
                        bit_cnt_q  <= '0;
                    end
                end
                RX_START: begin
                    if (bit_cnt_q == C_HALF_LAST) begin
                        bit_cnt_q  <= '0;
                        bit_idx_q  <= '0;
                        rx_state_q <= sync2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (bit_tick_w) begin
                        bit_cnt_q <= '0;
                        shift_q   <= {sync2_q, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            rx_state_q <= RX_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (bit_tick_w) begin
                        bit_cnt_q  <= '0;
                        rx_state_q <= RX_IDLE;
                        byte_stb_q <= sync2_q;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Packet parser, acceptance and watchdog
    // ------------------------------------------------------------------
    p_state_t         p_state_q;
    logic             run_flag_q;
    logic [7:0]       dir_h_q;
    logic [7:0]       dir_l_q;
    logic [7:0]       spd_h_q;
    logic [7:0]       spd_l_q;
    logic [7:0]       sum_q;
    logic [GAP_W-1:0] gap_q;
    logic [WD_W-1:0]  wd_q;

    logic [15:0]      dir_w;
    logic             pkt_ok_w;
    logic             accept_w;

    // shift_q is stable while byte_stb_q is high: the next shift is at
    // least half a bit period away.
    assign dir_w    = {dir_h_q, dir_l_q};
    assign pkt_ok_w = (shift_q == sum_q) && (dir_w <= C_DIR_MAX) &&
                      (spd_h_q[7:2] == 6'd0);
    assign accept_w = byte_stb_q && (p_state_q == P_CSUM) && pkt_ok_w;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p_state_q    <= P_HDR;
            run_flag_q   <= 1'b0;
            dir_h_q      <= '0;
            dir_l_q      <= '0;
            spd_h_q      <= '0;
            spd_l_q      <= '0;
            sum_q        <= '0;
            gap_q        <= '0;
            wd_q         <= '0;
            dir_degrees  <= '0;
            target_speed <= '0;
            run_en       <= 1'b0;
            cmd_valid    <= 1'b0;
            cmd_err      <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            cmd_err   <= 1'b0;

            // Gap counter saturates at its last value; only meaningful
            // while a packet is in progress.
            if (byte_stb_q || (p_state_q == P_HDR)) begin
                gap_q <= '0;
            end else if (gap_q != C_GAP_LAST) begin
                gap_q <= gap_q + GAP_W'(1);
            end

            if (frame_err_w) begin
                p_state_q <= P_HDR;
                cmd_err   <= 1'b1;
            end else if (byte_stb_q) begin
                case (p_state_q)
                    P_HDR: begin
                        if (shift_q == C_HDR_BYTE) begin
                            p_state_q <= P_FLAGS;
                        end
                    end
                    P_FLAGS: begin
                        run_flag_q <= shift_q[0];
                        sum_q      <= shift_q;
                        p_state_q  <= P_DIR_H;
                    end
                    P_DIR_H: begin
                        dir_h_q   <= shift_q;
                        sum_q     <= sum_q + shift_q;
                        p_state_q <= P_DIR_L;
                    end
                    P_DIR_L: begin
                        dir_l_q   <= shift_q;
                        sum_q     <= sum_q + shift_q;
                        p_state_q <= P_SPD_H;
                    end
                    P_SPD_H: begin
                        spd_h_q   <= shift_q;
                        sum_q     <= sum_q + shift_q;
                        p_state_q <= P_SPD_L;
                    end
                    P_SPD_L: begin
                        spd_l_q   <= shift_q;
                        sum_q     <= sum_q + shift_q;
                        p_state_q <= P_CSUM;
                    end
                    P_CSUM: begin
                        if (pkt_ok_w) begin
                            dir_degrees  <= dir_w[8:0];
                            target_speed <= {spd_h_q[1:0], spd_l_q};
                            cmd_valid    <= 1'b1;
                        end else begin
                            cmd_err <= 1'b1;
                        end
                        p_state_q <= P_HDR;
                    end
                    default: p_state_q <= P_HDR;
                endcase
            end else if ((p_state_q != P_HDR) && (gap_q == C_GAP_LAST)) begin
                // Abandoned fragment: silently resynchronise.
                p_state_q <= P_HDR;
            end

            // Watchdog: an accepted packet takes priority over expiry.
            if (accept_w) begin
                run_en <= run_flag_q;
                wd_q   <= '0;
            end else if (run_en) begin
                if (wd_q == C_WD_LAST) begin
                    run_en <= 1'b0;
                    wd_q   <= '0;
                end else begin
                    wd_q <= wd_q + WD_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ble_cmd_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ble_cmd_rx
//  Purpose  : Directed self-checking bench for ble_cmd_rx (CLKS_PER_BIT=8,
//             BYTE_GAP_CLKS=200, WATCHDOG_CLKS=2000).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ble_cmd_rx;

    localparam logic [55:0] P_VALID  = 56'hA5_01_00_5A_01_F4_50; // 90/500/run
    localparam logic [55:0] P_BADSUM = 56'hA5_01_00_5A_01_F4_51;
    localparam logic [55:0] P_DIR360 = 56'hA5_01_01_68_00_64_CE;
    localparam logic [55:0] P_SPD1K  = 56'hA5_01_00_0A_04_00_0F;
    localparam logic [55:0] P_DIR359 = 56'hA5_01_01_67_00_00_69; // 359/0/run
    localparam logic [55:0] P_300    = 56'hA5_00_01_2C_03_FF_2F; // 300/1023/stop

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       uart_rx = 1'b1;
    logic [8:0] dir_degrees;
    logic [9:0] target_speed;
    logic       run_en;
    logic       cmd_valid;
    logic       cmd_err;

    int checks = 0;
    int errors = 0;

    // Pulse monitor, sampled on the falling edge.
    int   cyc = 0;
    int   n_valid = 0;
    int   n_err = 0;
    int   n_both = 0;
    int   last_valid_cyc = 0;
    int   fall_cyc = 0;
    logic run_prev = 1'b0;

    ble_cmd_rx #(
        .CLKS_PER_BIT (8),
        .BYTE_GAP_CLKS(200),
        .WATCHDOG_CLKS(2000)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .uart_rx     (uart_rx),
        .dir_degrees (dir_degrees),
        .target_speed(target_speed),
        .run_en      (run_en),
        .cmd_valid   (cmd_valid),
        .cmd_err     (cmd_err)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (cmd_valid) begin
            n_valid        <= n_valid + 1;
            last_valid_cyc <= cyc;
        end
        if (cmd_err) n_err <= n_err + 1;
        if (cmd_valid && cmd_err) n_both <= n_both + 1;
        if (run_prev && !run_en) fall_cyc <= cyc;
        run_prev <= run_en;
    end

    task automatic idle(input int n);
        uart_rx = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        for (int n = 0; n < 80; n++) begin
            int k;
            @(negedge clock);
            k = n / 8;
            if (k == 0)      uart_rx = 1'b0;
            else if (k <= 8) uart_rx = b[k-1];
            else             uart_rx = stop;
        end
    endtask

    task automatic send_pkt(input logic [55:0] p);
        for (int i = 0; i < 7; i++) send_byte(p[55-8*i -: 8], 1'b1);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        if ({dir_degrees, target_speed, run_en, cmd_valid, cmd_err} !== 22'd0) begin
            $display("FAIL reset_hold: got %h expected 0",
                     {dir_degrees, target_speed, run_en, cmd_valid, cmd_err});
            errors++;
        end
        checks++;
        reset = 1'b0;
        idle(5);
        if ({dir_degrees, target_speed, run_en, cmd_valid, cmd_err} !== 22'd0) begin
            $display("FAIL reset_release: got %h expected 0",
                     {dir_degrees, target_speed, run_en, cmd_valid, cmd_err});
            errors++;
        end
        checks++;
    endtask

    task automatic test_checksum_err;
        int v0 = n_valid;
        int e0 = n_err;
        send_pkt(P_BADSUM);
        idle(10);
        if (n_err - e0 !== 1) begin
            $display("FAIL csum_err_pulses: got %0d expected 1", n_err - e0); errors++;
        end
        checks++;
        if (n_valid - v0 !== 0) begin
            $display("FAIL csum_valid_pulses: got %0d expected 0", n_valid - v0); errors++;
        end
        checks++;
        if ({dir_degrees, target_speed, run_en} !== 20'd0) begin
            $display("FAIL csum_outputs: got %0d/%0d/%0d expected 0/0/0",
                     dir_degrees, target_speed, run_en); errors++;
        end
        checks++;
    endtask

    task automatic test_range_err;
        int v0 = n_valid;
        int e0 = n_err;
        send_pkt(P_DIR360);
        idle(10);
        if (n_err - e0 !== 1) begin
            $display("FAIL dir360_err_pulses: got %0d expected 1", n_err - e0); errors++;
        end
        checks++;
        send_pkt(P_SPD1K);
        idle(10);
        if (n_err - e0 !== 2) begin
            $display("FAIL spd1024_err_pulses: got %0d expected 2", n_err - e0); errors++;
        end
        checks++;
        if (n_valid - v0 !== 0) begin
            $display("FAIL range_valid_pulses: got %0d expected 0", n_valid - v0); errors++;
        end
        checks++;
        if ({dir_degrees, target_speed, run_en} !== 20'd0) begin
            $display("FAIL range_outputs: got %0d/%0d/%0d expected 0/0/0",
                     dir_degrees, target_speed, run_en); errors++;
        end
        checks++;
    endtask

    task automatic test_valid;
        int v0 = n_valid;
        int e0 = n_err;
        send_pkt(P_VALID);
        idle(10);
        if (n_valid - v0 !== 1 || n_err - e0 !== 0) begin
            $display("FAIL valid_pulses: got valid %0d err %0d expected 1 0",
                     n_valid - v0, n_err - e0); errors++;
        end
        checks++;
        if (dir_degrees !== 9'd90 || target_speed !== 10'd500 || run_en !== 1'b1) begin
            $display("FAIL valid_outputs: got %0d/%0d/%0d expected 90/500/1",
                     dir_degrees, target_speed, run_en); errors++;
        end
        checks++;
    endtask

    task automatic test_boundary;
        int v0 = n_valid;
        send_pkt(P_DIR359);
        idle(10);
        if (n_valid - v0 !== 1 || dir_degrees !== 9'd359 || target_speed !== 10'd0 ||
            run_en !== 1'b1) begin
            $display("FAIL dir359: got n=%0d %0d/%0d/%0d expected n=1 359/0/1",
                     n_valid - v0, dir_degrees, target_speed, run_en); errors++;
        end
        checks++;
    endtask

    task automatic test_back_to_back;
        int v0 = n_valid;
        int e0 = n_err;
        send_pkt(P_300);
        idle(10);
        if (dir_degrees !== 9'd300 || target_speed !== 10'd1023 || run_en !== 1'b0) begin
            $display("FAIL spd1023: got %0d/%0d/%0d expected 300/1023/0",
                     dir_degrees, target_speed, run_en); errors++;
        end
        checks++;
        send_pkt(P_300);
        send_pkt(P_VALID);
        idle(10);
        if (n_valid - v0 !== 3 || n_err - e0 !== 0) begin
            $display("FAIL b2b_pulses: got valid %0d err %0d expected 3 0",
                     n_valid - v0, n_err - e0); errors++;
        end
        checks++;
        if (dir_degrees !== 9'd90 || target_speed !== 10'd500 || run_en !== 1'b1) begin
            $display("FAIL b2b_outputs: got %0d/%0d/%0d expected 90/500/1",
                     dir_degrees, target_speed, run_en); errors++;
        end
        checks++;
    endtask

    task automatic test_resync;
        int v0;
        int e0;
        send_pkt(P_300);
        idle(10);
        v0 = n_valid;
        e0 = n_err;
        send_byte(8'h13, 1'b1);
        send_byte(8'h37, 1'b1);
        send_pkt(P_VALID);
        idle(10);
        if (n_valid - v0 !== 1 || n_err - e0 !== 0 || dir_degrees !== 9'd90 ||
            target_speed !== 10'd500) begin
            $display("FAIL resync: got valid %0d err %0d dir %0d spd %0d expected 1 0 90 500",
                     n_valid - v0, n_err - e0, dir_degrees, target_speed); errors++;
        end
        checks++;
    endtask

    task automatic test_gap;
        int v0;
        int e0;
        send_pkt(P_300);
        idle(10);
        v0 = n_valid;
        e0 = n_err;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        idle(250);
        send_pkt(P_VALID);
        idle(10);
        if (n_valid - v0 !== 1 || n_err - e0 !== 0 || dir_degrees !== 9'd90 ||
            target_speed !== 10'd500) begin
            $display("FAIL gap_timeout: got valid %0d err %0d dir %0d spd %0d expected 1 0 90 500",
                     n_valid - v0, n_err - e0, dir_degrees, target_speed); errors++;
        end
        checks++;
    endtask

    task automatic test_framing;
        int v0;
        int e0;
        int err_at = -1;
        int seen = 0;
        logic [7:0] b = 8'h5A;
        send_pkt(P_300);
        idle(10);
        v0 = n_valid;
        e0 = n_err;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        // DIR_L byte with its stop bit held low.
        @(negedge clock);
        uart_rx = 1'b0;
        for (int n = 1; n <= 90; n++) begin
            int k;
            @(negedge clock);
            if (cmd_err) begin
                seen++;
                if (err_at < 0) err_at = n;
            end
            k = n / 8;
            if (k == 0)      uart_rx = 1'b0;
            else if (k <= 8) uart_rx = b[k-1];
            else if (k == 9) uart_rx = 1'b0;
            else             uart_rx = 1'b1;
        end
        if (err_at !== 79 || seen !== 1) begin
            $display("FAIL framing_err_time: got cycle %0d count %0d expected cycle 79 count 1",
                     err_at, seen); errors++;
        end
        checks++;
        idle(20);
        if (n_valid - v0 !== 0 || dir_degrees !== 9'd300) begin
            $display("FAIL framing_hold: got valid %0d dir %0d expected 0 300",
                     n_valid - v0, dir_degrees); errors++;
        end
        checks++;
        send_pkt(P_VALID);
        idle(10);
        if (n_valid - v0 !== 1 || n_err - e0 !== 1 || dir_degrees !== 9'd90) begin
            $display("FAIL framing_recover: got valid %0d err %0d dir %0d expected 1 1 90",
                     n_valid - v0, n_err - e0, dir_degrees); errors++;
        end
        checks++;
    endtask

    task automatic test_reset_mid;
        int v0;
        int e0;
        logic [7:0] b = 8'h01;
        send_pkt(P_VALID);
        idle(10);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h5A, 1'b1);
        for (int n = 0; n < 40; n++) begin
            int k;
            @(negedge clock);
            k = n / 8;
            if (k == 0) uart_rx = 1'b0;
            else        uart_rx = b[k-1];
        end
        reset = 1'b1;
        uart_rx = 1'b1;
        repeat (2) @(negedge clock);
        if ({dir_degrees, target_speed, run_en} !== 20'd0) begin
            $display("FAIL midreset_outputs: got %0d/%0d/%0d expected 0/0/0",
                     dir_degrees, target_speed, run_en); errors++;
        end
        checks++;
        reset = 1'b0;
        v0 = n_valid;
        e0 = n_err;
        idle(20);
        send_pkt(P_300);
        idle(10);
        if (n_valid - v0 !== 1 || n_err - e0 !== 0 || dir_degrees !== 9'd300 ||
            target_speed !== 10'd1023 || run_en !== 1'b0) begin
            $display("FAIL midreset_next: got valid %0d err %0d %0d/%0d/%0d expected 1 0 300/1023/0",
                     n_valid - v0, n_err - e0, dir_degrees, target_speed, run_en); errors++;
        end
        checks++;
    endtask

    task automatic test_watchdog;
        int waited = 0;
        send_pkt(P_VALID);
        idle(2);
        if (run_en !== 1'b1) begin
            $display("FAIL wd_start_run: got %0d expected 1", run_en); errors++;
        end
        checks++;
        while (run_en === 1'b1 && waited < 2100) begin
            @(negedge clock);
            waited++;
        end
        if (run_en !== 1'b0) begin
            $display("FAIL wd_timeout: run_en got %0d expected 0 within 2100 cycles", run_en);
            errors++;
        end
        checks++;
        idle(2);
        if (fall_cyc - last_valid_cyc !== 2000) begin
            $display("FAIL wd_latency: got %0d expected 2000", fall_cyc - last_valid_cyc);
            errors++;
        end
        checks++;
        if (dir_degrees !== 9'd90 || target_speed !== 10'd500) begin
            $display("FAIL wd_hold: got %0d/%0d expected 90/500", dir_degrees, target_speed);
            errors++;
        end
        checks++;
        send_pkt(P_VALID);
        idle(10);
        if (run_en !== 1'b1) begin
            $display("FAIL wd_restore: got %0d expected 1", run_en); errors++;
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_checksum_err();
        test_range_err();
        test_valid();
        test_boundary();
        test_back_to_back();
        test_resync();
        test_gap();
        test_framing();
        test_reset_mid();
        test_watchdog();
        if (n_both !== 0) begin
            $display("FAIL valid_err_overlap: got %0d expected 0", n_both); errors++;
        end
        checks++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ble_cmd_rx.md
# ble_cmd_rx

Receives the serial byte stream from the BLE module's UART TX pin, frames fixed-length 7-byte drive command packets, validates them, and presents the motion command to the drive stage. Outputs are the heading, the target speed and the run enable that feed the motor-direction and speed logic ahead of the two MotorDriver instances. A watchdog drops run_en if valid commands stop arriving.

## Interface

Parameters:
- CLKS_PER_BIT, default 868: clock cycles per UART bit (100 MHz / 115200 baud); must be at least 4.
- BYTE_GAP_CLKS, default 200000: maximum idle cycles between bytes inside one packet.
- WATCHDOG_CLKS, default 50000000: cycles without a valid packet before run_en is forced low (0.5 s).

Ports:
- clock  in  1  system clock; the block's only clock.
- reset  in  1  asynchronous, active-high reset.
- uart_rx  in  1  serial data from BLE_UART_TX; asynchronous to clock; idles high.
- dir_degrees  out  9  commanded heading, 0–359.
- target_speed  out  10  commanded speed, 0–1023.
- run_en  out  1  motors enabled.
- cmd_valid  out  1  one-cycle pulse when a packet is accepted.
- cmd_err  out  1  one-cycle pulse when a packet is rejected.

## Operation

- **Input synchronizer:** uart_rx passes through a 2-flop synchronizer, reset to 1. All logic below uses the synchronized value.
- **UART receiver:** 8N1, LSB first. A falling edge in IDLE starts a timer.
  - At CLKS_PER_BIT/2 the start bit is checked. If the line is high, return to IDLE with no error.
  - Each data bit and the stop bit is then sampled every CLKS_PER_BIT.
  - Stop bit = 1: produce a one-cycle internal byte strobe.
  - Stop bit = 0: framing error. The byte is discarded, the parser returns to HDR and cmd_err pulses.
- **Packet format:** 0xA5, FLAGS, DIR_H, DIR_L, SPD_H, SPD_L, CSUM.
  - run = FLAGS[0]; FLAGS[7:1] are ignored.
  - dir = {DIR_H, DIR_L}; speed = {SPD_H, SPD_L}.
  - CSUM = (FLAGS + DIR_H + DIR_L + SPD_H + SPD_L) mod 256.
- **Parser FSM:** HDR → FLAGS → DIR_H → DIR_L → SPD_H → SPD_L → CSUM → HDR.
  - Each transition happens on a byte strobe.
  - In HDR, any byte other than 0xA5 is silently dropped.
  - 0xA5 appearing in a payload position is payload, not a header.
- **Byte-gap timeout:** a gap counter clears on every byte strobe. If it reaches BYTE_GAP_CLKS while the parser is not in HDR, the parser returns to HDR with no cmd_err.
- **Acceptance:** a packet is accepted only if the checksum matches, dir ≤ 359 and SPD_H[7:2] = 0.
  - Accepted: dir_degrees, target_speed and run_en load from the packet; cmd_valid pulses.
  - Rejected: cmd_err pulses and all outputs hold their values.
- **Watchdog:**
  - Counts only while run_en = 1 and clears on every cmd_valid.
  - On reaching WATCHDOG_CLKS, run_en goes to 0 while dir_degrees and target_speed hold. The counter stops.
  - A later valid packet restores run_en from FLAGS[0].
- **Reset:** may assert at any point, including mid-byte or mid-packet. The receiver goes to IDLE, the parser to HDR, all counters clear and the partial packet is lost.

## Timing

- **Reset values:** dir_degrees 0, target_speed 0, run_en 0, cmd_valid 0, cmd_err 0; synchronizer flops 1.
- **Synchronizer latency:** 2 cycles from a uart_rx edge to the receiver seeing it.
- **Byte strobe:** 1 cycle after the stop-bit sample.
- **Packet latency:** cmd_valid/cmd_err and the output update occur on the cycle after the CSUM byte strobe. Outputs change in the same cycle cmd_valid is high.
- **Framing-error latency:** cmd_err pulses 1 cycle after the failing stop-bit sample.
- **Mutual exclusion:** cmd_valid and cmd_err are never high together.
- **Watchdog vs. packet:** if watchdog expiry and cmd_valid fall in the same cycle, cmd_valid wins. run_en takes FLAGS[0] and the counter clears.
- **Back-to-back bytes:** stop bit followed immediately by the next start bit must be received without loss.

## Test plan

All scenarios use CLKS_PER_BIT=8, BYTE_GAP_CLKS=200 and WATCHDOG_CLKS=2000.

- **Valid packet:** send A5 01 00 5A 01 F4 50 → one cmd_valid pulse; dir_degrees=90, target_speed=500, run_en=1.
- **Checksum error:** send A5 01 00 5A 01 F4 51 → one cmd_err pulse; outputs keep their prior values (0/0/0 from reset).
- **Range error:** send A5 01 01 68 00 64 CE (dir 360) → cmd_err. Send A5 01 00 0A 04 00 0F (speed 1024) → cmd_err. Outputs unchanged in both cases.
- **Resync and gap:**
  - Send 13 37, then the valid packet → accepted.
  - Send A5 01 00, idle 250 cycles, then send the valid packet → accepted, with no cmd_err from the abandoned fragment.
- **Framing error and reset:**
  - Stop bit forced low on the DIR_L byte → cmd_err 1 cycle after the sample; a following valid packet is accepted.
  - Reset asserted mid-SPD_H → all outputs 0, and the next full packet is accepted.
- **Watchdog:**
  - After the valid run packet, hold uart_rx high → run_en falls exactly 2000 cycles after cmd_valid, with dir_degrees=90 and target_speed=500 held.
  - Resend the packet → run_en=1.
